spi_sck_gen: RTL and testbench

SPI_SCK_GEN -- requirements
Module: spi_sck_gen

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_half_period_div.sv | 54 +++++
 rtl/spi_sck_gen.sv | 168 ++++++++++++++++
 tb/tb_spi_sck_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI serial-clock generator.
package spi_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } spi_state_e;

    // Edge counter must hold 0..2*data_w inclusive.
    function automatic int edge_cnt_w(input int data_w);
        return $clog2(2 * data_w + 1);
    endfunction

endpackage

// File: rtl/spi_half_period_div.sv
// Two-stage half-period divider: linear prescaler 0..sppr feeding a binary stage 0..2^spr-1.
module spi_half_period_div #(
    parameter int PRE_W = 3,
    parameter int SPR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] sppr,
    input  logic [SPR_W-1:0] spr,
    output logic             tick
);

    // Binary stage is wide enough for the largest power-of-two select.
    localparam int BIN_W = (1 << SPR_W) - 1;

    logic [PRE_W-1:0] lin_r;
    logic [BIN_W-1:0] bin_r;
    logic [BIN_W-1:0] bin_mask_s;
    logic             lin_tc_s;
    logic             bin_tc_s;

    // Terminal-count decode; tick is the half-period boundary.
    always_comb begin
        bin_mask_s = ~({BIN_W{1'b1}} << spr);
        lin_tc_s   = (lin_r == sppr);
        bin_tc_s   = (bin_r == bin_mask_s);
        tick       = lin_tc_s && bin_tc_s;
    end

    // Cascaded counters; clr dominates the enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lin_r <= '0;
            bin_r <= '0;
        end else if (clr) begin
            lin_r <= '0;
            bin_r <= '0;
        end else if (en) begin
            if (lin_tc_s) begin
                lin_r <= '0;
                if (bin_tc_s) begin
                    bin_r <= '0;
                end else begin
                    bin_r <= bin_r + BIN_W'(1);
                end
            end else begin
                lin_r <= lin_r + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_sck_gen.sv
// SPI master serial-clock generator: produces SCK plus sample/shift strobes for one frame.
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int PRE_W  = 3,
    parameter int SPR_W  = 3,
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             start,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [PRE_W-1:0] sppr,
    input  logic [SPR_W-1:0] spr,
    output logic             sck,
    output logic             sample_stb,
    output logic             shift_stb,
    output logic             busy,
    output logic             done
);

    localparam int                EDGE_W    = edge_cnt_w(DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

    spi_state_e        state_r, state_s;
    logic [EDGE_W-1:0] edge_cnt_r, edge_cnt_s;
    logic              sck_r, sck_s;
    logic              sample_r, sample_s;
    logic              shift_r, shift_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              cpol_r, cpol_s;
    logic              cpha_r, cpha_s;
    logic [PRE_W-1:0]  sppr_r, sppr_s;
    logic [SPR_W-1:0]  spr_r, spr_s;
    logic              tick_s;
    logic              leading_s;
    logic              final_edge_s;
    logic              div_en_s;
    logic              div_clr_s;

    // Divider only counts while a frame is running; it rests at zero otherwise.
    always_comb begin
        div_en_s  = en && (state_r == ST_RUN);
        div_clr_s = clr || (state_r != ST_RUN);
    end

    spi_half_period_div #(
        .PRE_W (PRE_W),
        .SPR_W (SPR_W)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en_s),
        .clr  (div_clr_s),
        .sppr (sppr_r),
        .spr  (spr_r),
        .tick (tick_s)
    );

    // Next-state, SCK and strobe decode; the upcoming edge is edge_cnt_r+1.
    always_comb begin
        state_s      = state_r;
        edge_cnt_s   = edge_cnt_r;
        sck_s        = sck_r;
        sample_s     = 1'b0;
        shift_s      = 1'b0;
        busy_s       = busy_r;
        done_s       = 1'b0;
        cpol_s       = cpol_r;
        cpha_s       = cpha_r;
        sppr_s       = sppr_r;
        spr_s        = spr_r;
        leading_s    = ~edge_cnt_r[0];
        final_edge_s = (edge_cnt_r == (LAST_EDGE - EDGE_W'(1)));
        case (state_r)
            ST_IDLE: begin
                sck_s      = cpol;
                busy_s     = 1'b0;
                edge_cnt_s = '0;
                if (start) begin
                    state_s = ST_RUN;
                    busy_s  = 1'b1;
                    cpol_s  = cpol;
                    cpha_s  = cpha;
                    sppr_s  = sppr;
                    spr_s   = spr;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (edge_cnt_r == LAST_EDGE) begin
                    state_s    = ST_IDLE;
                    edge_cnt_s = '0;
                    busy_s     = 1'b0;
                    done_s     = 1'b1;
                    sck_s      = cpol_r;
                end else if (tick_s) begin
                    edge_cnt_s = edge_cnt_r + EDGE_W'(1);
                    sck_s      = ~sck_r;
                    if (cpha_r) begin
                        shift_s  = leading_s;
                        sample_s = ~leading_s;
                    end else begin
                        sample_s = leading_s;
                        shift_s  = ~leading_s && !final_edge_s;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                edge_cnt_s = '0;
                busy_s     = 1'b0;
                sck_s      = cpol;
            end
        endcase
    end

    // State and output registers; en low freezes everything, clr returns to idle without done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            edge_cnt_r <= '0;
            sck_r      <= 1'b0;
            sample_r   <= 1'b0;
            shift_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            cpol_r     <= 1'b0;
            cpha_r     <= 1'b0;
            sppr_r     <= '0;
            spr_r      <= '0;
        end else if (clr) begin
            state_r    <= ST_IDLE;
            edge_cnt_r <= '0;
            sck_r      <= cpol;
            sample_r   <= 1'b0;
            shift_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (en) begin
            state_r    <= state_s;
            edge_cnt_r <= edge_cnt_s;
            sck_r      <= sck_s;
            sample_r   <= sample_s;
            shift_r    <= shift_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            cpol_r     <= cpol_s;
            cpha_r     <= cpha_s;
            sppr_r     <= sppr_s;
            spr_r      <= spr_s;
        end
    end

    assign sck        = sck_r;
    assign sample_stb = sample_r;
    assign shift_stb  = shift_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_spi_sck_gen.sv
// Directed self-checking bench for spi_sck_gen with a per-cycle expected-output model.
module tb_spi_sck_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       en;
    logic       start;
    logic       cpol;
    logic       cpha;
    logic [2:0] sppr;
    logic [2:0] spr;
    logic       sck;
    logic       sample_stb;
    logic       shift_stb;
    logic       busy;
    logic       done;
    logic [4:0] obs;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    spi_sck_gen #(
        .PRE_W  (3),
        .SPR_W  (3),
        .DATA_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .en         (en),
        .start      (start),
        .cpol       (cpol),
        .cpha       (cpha),
        .sppr       (sppr),
        .spr        (spr),
        .sck        (sck),
        .sample_stb (sample_stb),
        .shift_stb  (shift_stb),
        .busy       (busy),
        .done       (done)
    );

    // Observed vector layout: {busy, done, sck, sample_stb, shift_stb}
    assign obs = {busy, done, sck, sample_stb, shift_stb};

    task automatic check(input string tag, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s t=%0t: got %b expected %b ({busy,done,sck,sample,shift})", tag, $time, act, exp);
        end
    endtask

    // Expected outputs after a enabled cycles since busy rose, half-period h, 16 edges per frame.
    function automatic logic [4:0] model(input int a, input int h, input bit cp, input bit ph);
        int k;
        bit at_edge;
        bit lead;
        bit smp;
        bit shf;
        if (a > 16 * h) begin
            return {1'b0, 1'b1, cp, 1'b0, 1'b0};
        end
        k       = a / h;
        at_edge = (a != 0) && ((a % h) == 0);
        lead    = (k % 2) == 1;
        smp     = at_edge && (ph ? !lead : lead);
        shf     = at_edge && (ph ? lead : (!lead && k != 16));
        return {1'b1, 1'b0, cp ^ lead, smp, shf};
    endfunction

    // Runs one full frame from the current negedge, checking every cycle.
    task automatic run_frame(input string tag, input bit cp, input bit ph, input logic [2:0] pr,
                             input logic [2:0] sr, input int h, input int fa, input int flen,
                             input bit mutate);
        int a;
        cpol  = cp;
        cpha  = ph;
        sppr  = pr;
        spr   = sr;
        en    = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 0;
        check({tag, "_start"}, obs, model(a, h, cp, ph));
        if (mutate) begin
            sppr  = ~pr;
            spr   = ~sr;
            cpol  = ~cp;
            cpha  = ~ph;
            start = 1'b1;
        end
        while (a <= 16 * h) begin
            if (a == fa) begin
                en = 1'b0;
                repeat (flen) begin
                    @(negedge clk);
                    start = 1'b0;
                    check({tag, "_frozen"}, obs, model(a, h, cp, ph));
                end
                en = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            a++;
            check(tag, obs, model(a, h, cp, ph));
        end
    endtask

    initial begin
        rst   = 1'b0;
        clr   = 1'b0;
        en    = 1'b0;
        start = 1'b0;
        cpol  = 1'b1;
        cpha  = 1'b0;
        sppr  = 3'd0;
        spr   = 3'd0;
        @(negedge clk);
        check("reset", obs, 5'b00000);

        rst = 1'b1;
        en  = 1'b1;
        @(negedge clk);
        check("idle_cpol1", obs, 5'b00100);
        en   = 1'b0;
        cpol = 1'b0;
        @(negedge clk);
        check("idle_en_hold", obs, 5'b00100);
        en = 1'b1;
        @(negedge clk);
        check("idle_cpol0", obs, 5'b00000);

        en    = 1'b0;
        start = 1'b1;
        @(negedge clk);
        en    = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("start_en_low", obs, 5'b00000);
        @(negedge clk);
        check("start_not_queued", obs, 5'b00000);

        run_frame("h1", 1'b0, 1'b0, 3'd0, 3'd0, 1, -1, 0, 1'b0);
        run_frame("h6", 1'b1, 1'b1, 3'd2, 3'd1, 6, -1, 0, 1'b0);
        run_frame("h1024", 1'b0, 1'b0, 3'd7, 3'd7, 1024, -1, 0, 1'b1);
        run_frame("freeze", 1'b0, 1'b1, 3'd1, 3'd0, 2, 10, 50, 1'b0);

        // Clear at edge 9: sck is high there, so returning to cpol=0 is visible.
        cpol  = 1'b0;
        cpha  = 1'b0;
        sppr  = 3'd1;
        spr   = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int a = 0; a <= 18; a++) begin
            if (a > 0) begin
                @(negedge clk);
            end
            check("pre_clr", obs, model(a, 2, 1'b0, 1'b0));
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_idle", obs, 5'b00000);
        repeat (20) begin
            @(negedge clk);
            check("clr_no_done", obs, 5'b00000);
        end
        clr   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
        start = 1'b0;
        check("clr_start", obs, 5'b00000);
        @(negedge clk);
        check("clr_start_after", obs, 5'b00000);

        run_frame("post_clr", 1'b1, 1'b0, 3'd0, 3'd1, 2, -1, 0, 1'b0);

        // Asynchronous reset in the middle of a frame.
        cpol  = 1'b0;
        cpha  = 1'b0;
        sppr  = 3'd0;
        spr   = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst", obs, model(5, 1, 1'b0, 1'b0));
        #2;
        rst = 1'b0;
        #1;
        check("rst_async", obs, 5'b00000);
        @(negedge clk);
        rst = 1'b1;
        run_frame("post_rst", 1'b0, 1'b0, 3'd3, 3'd0, 4, -1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
